// File: rtl/cnn_pkg.sv
// Shared types and constants for the conv-to-pool link.
// State encoding, data width and frame-size helpers.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    POOL,
    DONE
  } state_e;

  localparam int DATA_W = 16;
  localparam int N_DEF = 3;
  localparam int SIZE_DEF = 2 * N_DEF;
  localparam int FRAME_WORDS = SIZE_DEF * SIZE_DEF;

  function automatic int frame_words(input int size);
    return size * size;
  endfunction

endpackage

// File: rtl/conv_frame_buf.sv
// Frame buffer: WORDS x DATA_W array, one write port, one
// registered read port (1-cycle latency, zero when not reading).
// Ports: clk_i, rst_i, we_i/waddr_i/wdata_i, re_i/raddr_i, rdata_o.
module conv_frame_buf
  import cnn_pkg::*;
#(
  parameter int WORDS = FRAME_WORDS,
  parameter int IW    = 6
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [IW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [IW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // A write landing on the address being read in the same cycle
  // is forwarded, so a write issued with start is seen at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      if (we_i && (waddr_i == raddr_i)) rdata_q <= wdata_i;
      else                              rdata_q <= mem_q[raddr_i];
    end else begin
      rdata_q <= '0;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/conv_stream_tx.sv
// Streams a buffered SIZE x SIZE conv frame into the pooling stage,
// then enables pooling until done_pooling and pulses done.
module conv_stream_tx
  import cnn_pkg::*;
#(
  parameter int n         = 3,
  parameter int SIZE      = 2 * n,
  parameter int LAST_HOLD = 3,
  parameter int AW        = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] conv_out,
  output logic              en_reg,
  output logic              en_pooling,
  input  logic              done_pooling,
  output logic              busy,
  output logic              done
);

  localparam int FW = frame_words(SIZE);
  localparam int IW = (FW > 1) ? $clog2(FW) : 1;
  localparam logic [7:0] LAST_RC = 8'(SIZE - 1);
  localparam logic [2:0] LAST_H = 3'(LAST_HOLD - 1);

  state_e state_q, state_d;
  logic [7:0] row_q, row_d;
  logic [7:0] col_q, col_d;
  logic [2:0] hold_q, hold_d;
  logic en_reg_q, en_pool_q, busy_q, done_q;

  logic          wr_ok;
  logic          rd_en;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign wr_ok = (state_q == IDLE) && wr_en
              && (32'(wr_addr) < FW);
  assign wr_idx = wr_addr[IW-1:0];

  // Counters hold the word shown next cycle; the buffer is read
  // with that address now so its registered output lines up.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          row_d   = '0;
          col_d   = '0;
          hold_d  = '0;
        end
      end
      STREAM: begin
        if (col_q != LAST_RC) begin
          col_d = col_q + 8'd1;
        end else if (hold_q != LAST_H) begin
          hold_d = hold_q + 3'd1;
        end else if (row_q != LAST_RC) begin
          row_d  = row_q + 8'd1;
          col_d  = '0;
          hold_d = '0;
        end else begin
          state_d = POOL;
          row_d   = '0;
          col_d   = '0;
          hold_d  = '0;
        end
      end
      POOL: begin
        if (done_pooling) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_en  = (state_d == STREAM);
  assign rd_idx = IW'(int'(row_d) * SIZE + int'(col_d));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      hold_q    <= '0;
      en_reg_q  <= 1'b0;
      en_pool_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      hold_q    <= hold_d;
      en_reg_q  <= (state_d == STREAM);
      en_pool_q <= (state_d == POOL);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  conv_frame_buf #(
    .WORDS (FW),
    .IW    (IW)
  ) u_buf (
    .clk_i   (clk),
    .rst_i   (reset),
    .we_i    (wr_ok),
    .waddr_i (wr_idx),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (rd_idx),
    .rdata_o (conv_out)
  );

  assign en_reg     = en_reg_q;
  assign en_pooling = en_pool_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
